pwm_generator: RTL and testbench

- Fixed-period PWM generator with a programmable high time, given in clock cycles.
- A free-running period counter is compared against an active duty register to drive one PWM output.
- New duty values are captured on an update strobe and applied only at a period boundary, so the output never glitches.
- Used as a leaf block for motor, LED and servo drive, sitting between a control register and a pin.

---
 rtl/pwm_generator.sv | 88 ++++++++
 tb/tb_pwm_generator.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
// Fixed-period PWM generator. A free-running period counter is compared against a
// double-buffered duty register; new duty values only take effect at the period wrap.
module pwm_generator #(
    parameter int PERIOD = 100,
    parameter int DUTY_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] PWM_DUT_CYCLES,
    input  logic              update,
    output logic              PWM_OUT,
    output logic              period_start,
    output logic [DUTY_W-1:0] duty_active
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

    // A duty above the period length is saturated so the output is simply held high.
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        if (d > DUTY_MAX) begin
            return DUTY_MAX;
        end
        return d;
    endfunction

    logic [CNT_W-1:0]  cnt;
    logic [DUTY_W-1:0] pending;
    logic              pending_valid;

    logic              wrap;
    logic [DUTY_W-1:0] captured;
    logic [CNT_W-1:0]  cnt_next;
    logic [DUTY_W-1:0] pending_next;
    logic              pending_valid_next;
    logic [DUTY_W-1:0] duty_next;
    logic              pwm_next;
    logic              period_start_next;

    always_comb begin
        wrap               = (cnt == CNT_LAST);
        captured           = clamp_duty(PWM_DUT_CYCLES);
        cnt_next           = wrap ? '0 : cnt + CNT_W'(1);
        pending_next       = pending;
        pending_valid_next = pending_valid;
        duty_next          = duty_active;

        if (wrap) begin
            // A strobe landing on the wrap edge bypasses the pending buffer entirely.
            if (update) begin
                duty_next          = captured;
                pending_next       = captured;
                pending_valid_next = 1'b0;
            end else if (pending_valid) begin
                duty_next          = pending;
                pending_valid_next = 1'b0;
            end
        end else if (update) begin
            pending_next       = captured;
            pending_valid_next = 1'b1;
        end

        // Compare against the values being loaded so the output lines up with cnt.
        pwm_next          = (CMP_W'(cnt_next) < CMP_W'(duty_next));
        period_start_next = (cnt_next == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            duty_active   <= '0;
            PWM_OUT       <= 1'b0;
            period_start  <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            pending       <= pending_next;
            pending_valid <= pending_valid_next;
            duty_active   <= duty_next;
            PWM_OUT       <= pwm_next;
            period_start  <= period_start_next;
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed self-checking bench for pwm_generator with PERIOD=100, DUTY_W=16.
module tb_pwm_generator;

    logic        clk;
    logic        reset;
    logic        update;
    logic [15:0] duty_in;
    logic        PWM_OUT;
    logic        period_start;
    logic [15:0] duty_active;

    int compared   = 0;
    int mismatched = 0;
    int ph         = 0;

    pwm_generator #(
        .PERIOD(100),
        .DUTY_W(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PWM_DUT_CYCLES(duty_in),
        .update        (update),
        .PWM_OUT       (PWM_OUT),
        .period_start  (period_start),
        .duty_active   (duty_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ph is the bench's own notion of the counter value after the latest edge.
    task automatic tick();
        @(posedge clk);
        if (reset) ph = 0;
        else       ph = (ph == 99) ? 0 : ph + 1;
        #1;
    endtask

    task automatic chk(input logic e_pwm, input logic e_ps, input logic [15:0] e_duty,
                       input string tag);
        compared++;
        assert ({PWM_OUT, period_start, duty_active} === {e_pwm, e_ps, e_duty})
        else begin
            mismatched++;
            $error("FAIL %s ph=%0d: observed pwm=%b ps=%b duty=%0d, expected pwm=%b ps=%b duty=%0d",
                   tag, ph, PWM_OUT, period_start, duty_active, e_pwm, e_ps, e_duty);
        end
    endtask

    task automatic expect_cycle(input logic [15:0] e_duty, input string tag);
        chk((ph < int'(e_duty)) ? 1'b1 : 1'b0, (ph == 0) ? 1'b1 : 1'b0, e_duty, tag);
    endtask

    task automatic run(input int n, input logic [15:0] e_duty, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            expect_cycle(e_duty, tag);
        end
    endtask

    task automatic pulse(input logic [15:0] val, input logic [15:0] e_duty, input string tag);
        update  = 1'b1;
        duty_in = val;
        tick();
        update  = 1'b0;
        expect_cycle(e_duty, tag);
    endtask

    initial begin
        reset   = 1'b1;
        update  = 1'b0;
        duty_in = 16'd0;

        tick();
        chk(1'b0, 1'b0, 16'd0, "reset_1");
        tick();
        chk(1'b0, 1'b0, 16'd0, "reset_2");

        // Hold update with 50: first period stays low, then 50/50.
        reset   = 1'b0;
        update  = 1'b1;
        duty_in = 16'd50;
        run(99, 16'd0, "first_period_low");
        run(200, 16'd50, "duty50");
        update  = 1'b0;

        // Duty 0 for three periods, then 500 clamped to 100, then 100.
        pulse(16'd0, 16'd0, "duty0_apply");
        run(299, 16'd0, "duty0");
        pulse(16'd500, 16'd100, "clamp500_apply");
        run(99, 16'd100, "clamp500");
        pulse(16'd100, 16'd100, "duty100_apply");
        run(99, 16'd100, "duty100");

        // Mid-period strobe of 10 while running at 50.
        pulse(16'd50, 16'd50, "back50_apply");
        run(19, 16'd50, "run50_pre");
        pulse(16'd10, 16'd50, "strobe10_mid");
        run(79, 16'd50, "run50_hold");
        run(100, 16'd10, "duty10");

        // Two strobes in one period: last one wins.
        run(10, 16'd10, "pre_two");
        pulse(16'd30, 16'd10, "strobe30");
        run(20, 16'd10, "between");
        pulse(16'd70, 16'd10, "strobe70");
        run(68, 16'd10, "after70");
        run(100, 16'd70, "duty70");

        // Pending 60, then 25 on the wrap edge overrides it and clears pending.
        run(10, 16'd70, "pre_bypass");
        pulse(16'd60, 16'd70, "strobe60");
        run(89, 16'd70, "hold70");
        pulse(16'd25, 16'd25, "bypass25");
        run(99, 16'd25, "duty25");
        run(100, 16'd25, "duty25_no_stale");

        // Reset at cnt=37 while high with 40 pending: everything cleared.
        pulse(16'd80, 16'd80, "duty80_apply");
        run(30, 16'd80, "run80");
        pulse(16'd40, 16'd80, "strobe40");
        run(6, 16'd80, "to37");
        chk(1'b1, 1'b0, 16'd80, "high_at_37");
        reset = 1'b1;
        tick();
        chk(1'b0, 1'b0, 16'd0, "mid_reset");
        reset = 1'b0;
        tick();
        chk(1'b0, 1'b0, 16'd0, "post_reset_cnt1");
        run(98, 16'd0, "post_reset_low");
        run(100, 16'd0, "pending_lost");
        pulse(16'd20, 16'd20, "recover20");
        run(99, 16'd20, "duty20");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
